// File: rtl/ps2_key_receiver_if.sv
// PS/2 keyboard lines plus the decoded key event outputs of ps2_key_receiver.
// The master side drives the raw PS/2 lines; the slave side is the receiver.
interface ps2_key_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key;
    logic       key_pressed;
    logic       key_released;
    logic       key_extended;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  key, key_pressed, key_released, key_extended, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output key, key_pressed, key_released, key_extended, frame_err
    );
endinterface

// File: rtl/ps2_key_receiver.sv
// PS/2 scan-code-set-2 receiver: synchronises the bus, deserialises 11-bit frames,
// resolves E0/F0 prefixes and emits one-cycle make/break/error strobes.
module ps2_key_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input logic               clk,
    input logic               rst,
    ps2_key_receiver_if.slave bus
);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Synchronisers idle high so reset release never looks like a falling edge.
    logic ps2c_s1_q, ps2c_s2_q, ps2c_prev_q;
    logic ps2d_s1_q, ps2d_s2_q;
    logic fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps2c_s1_q   <= 1'b1;
            ps2c_s2_q   <= 1'b1;
            ps2c_prev_q <= 1'b1;
            ps2d_s1_q   <= 1'b1;
            ps2d_s2_q   <= 1'b1;
        end else begin
            ps2c_s1_q   <= bus.ps2_clk;
            ps2c_s2_q   <= ps2c_s1_q;
            ps2c_prev_q <= ps2c_s2_q;
            ps2d_s1_q   <= bus.ps2_data;
            ps2d_s2_q   <= ps2d_s1_q;
        end
    end

    assign fall = ps2c_prev_q & ~ps2c_s2_q;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             ext_pend_q, ext_pend_d;
    logic             brk_pend_q, brk_pend_d;
    logic [WDW-1:0]   wdog_q, wdog_d;
    logic [7:0]       key_q, key_d;
    logic             ext_q, ext_d;
    logic             pressed_q, pressed_d;
    logic             released_q, released_d;
    logic             err_q, err_d;
    logic             busy, timeout, valid;

    assign busy    = (state_q != IDLE);
    assign timeout = busy && (wdog_q >= WDW'(TIMEOUT_CYCLES - 1));
    // Odd parity: data ones plus parity bit must be odd, and stop must be 1.
    assign valid   = ps2d_s2_q && ((^shift_q) ^ parity_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            wdog_q     <= '0;
            key_q      <= '0;
            ext_q      <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            wdog_q     <= wdog_d;
            key_q      <= key_d;
            ext_q      <= ext_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        wdog_d     = '0;
        key_d      = key_q;
        ext_d      = ext_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        err_d      = 1'b0;

        // A timeout takes priority over a coincident fall, which is dropped.
        if (timeout) begin
            state_d    = IDLE;
            cnt_d      = '0;
            shift_d    = '0;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!ps2d_s2_q) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_d = {ps2d_s2_q, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    parity_d = ps2d_s2_q;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!valid) begin
                        err_d      = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end else if (shift_q == 8'hE0) begin
                        ext_pend_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        brk_pend_d = 1'b1;
                    end else begin
                        key_d      = shift_q;
                        ext_d      = ext_pend_q;
                        released_d = brk_pend_q;
                        pressed_d  = ~brk_pend_q;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (busy) begin
            wdog_d = wdog_q + WDW'(1);
        end
    end

    assign bus.key          = key_q;
    assign bus.key_extended = ext_q;
    assign bus.key_pressed  = pressed_q;
    assign bus.key_released = released_q;
    assign bus.frame_err    = err_q;
endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver: one task per scenario, hand-computed expectations.
module tb_ps2_key_receiver;
    localparam int HALF = 50;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cnt_p = 0, cnt_r = 0, cnt_e = 0, excl_viol = 0;

    ps2_key_receiver_if bus ();

    ps2_key_receiver #(.TIMEOUT_CYCLES(200)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.key_pressed  === 1'b1) cnt_p++;
        if (bus.key_released === 1'b1) cnt_r++;
        if (bus.frame_err    === 1'b1) cnt_e++;
        if ((bus.key_pressed & bus.key_released) === 1'b1 ||
            (bus.frame_err & (bus.key_pressed | bus.key_released)) === 1'b1)
            excl_viol++;
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.ps2_data = b;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
        @(negedge clk);
        bus.ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, ~^d, 1'b1);
    endtask

    task automatic test_reset;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({bus.key, bus.key_pressed, bus.key_released, bus.key_extended, bus.frame_err} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got key=%h p=%b r=%b x=%b e=%b, want all 0",
                     bus.key, bus.key_pressed, bus.key_released, bus.key_extended, bus.frame_err);
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (cnt_p + cnt_r + cnt_e !== 0) begin
            n_err++;
            $display("FAIL reset_release_strobe: got %0d strobes, want 0", cnt_p + cnt_r + cnt_e);
        end
        $display("reset: done");
    endtask

    task automatic test_make;
        logic [7:0] d;
        logic [3:0] seen;
        int p0;
        d = 8'h1D;
        p0 = cnt_p;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(1'b1);
        @(negedge clk);
        bus.ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen[i] = bus.key_pressed;
        end
        repeat (HALF - 4) @(negedge clk);
        bus.ps2_clk = 1'b1;
        n_cmp++;
        if (seen !== 4'b0100) begin
            n_err++;
            $display("FAIL make_timing: key_pressed over edges 1..4 got %b, want 0,0,1,0 (bit3..0=%b)", seen, 4'b0100);
        end
        n_cmp++;
        if (bus.key !== 8'h1D || bus.key_extended !== 1'b0) begin
            n_err++;
            $display("FAIL make_key: got key=%h ext=%b, want key=1d ext=0", bus.key, bus.key_extended);
        end
        n_cmp++;
        if (cnt_p - p0 !== 1) begin
            n_err++;
            $display("FAIL make_count: got %0d pressed, want 1", cnt_p - p0);
        end
        $display("make 1D: key=%h", bus.key);
    endtask

    task automatic test_break;
        int p0, r0;
        p0 = cnt_p; r0 = cnt_r;
        send_byte(8'hF0);
        n_cmp++;
        if (cnt_p - p0 + cnt_r - r0 !== 0 || bus.key !== 8'h1D) begin
            n_err++;
            $display("FAIL break_prefix: got %0d strobes key=%h, want 0 strobes key=1d",
                     cnt_p - p0 + cnt_r - r0, bus.key);
        end
        send_byte(8'h1C);
        n_cmp++;
        if (cnt_r - r0 !== 1 || cnt_p - p0 !== 0 || bus.key !== 8'h1C) begin
            n_err++;
            $display("FAIL break_event: got rel=%0d prs=%0d key=%h, want rel=1 prs=0 key=1c",
                     cnt_r - r0, cnt_p - p0, bus.key);
        end
        $display("break F0 1C: key=%h", bus.key);
    endtask

    task automatic test_extended;
        int p0, r0;
        p0 = cnt_p; r0 = cnt_r;
        send_byte(8'hE0);
        send_byte(8'h75);
        n_cmp++;
        if (cnt_p - p0 !== 1 || bus.key !== 8'h75 || bus.key_extended !== 1'b1) begin
            n_err++;
            $display("FAIL ext_make: got prs=%0d key=%h ext=%b, want prs=1 key=75 ext=1",
                     cnt_p - p0, bus.key, bus.key_extended);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        n_cmp++;
        if (cnt_r - r0 !== 1 || cnt_p - p0 !== 1 || bus.key_extended !== 1'b1) begin
            n_err++;
            $display("FAIL ext_break: got rel=%0d prs=%0d ext=%b, want rel=1 prs=1 ext=1",
                     cnt_r - r0, cnt_p - p0, bus.key_extended);
        end
        send_byte(8'h23);
        n_cmp++;
        if (cnt_p - p0 !== 2 || bus.key !== 8'h23 || bus.key_extended !== 1'b0) begin
            n_err++;
            $display("FAIL ext_plain: got prs=%0d key=%h ext=%b, want prs=2 key=23 ext=0",
                     cnt_p - p0, bus.key, bus.key_extended);
        end
        $display("extended E0 75 / E0 F0 75 / 23: key=%h", bus.key);
    endtask

    task automatic test_parity_err;
        int p0, r0, e0;
        p0 = cnt_p; r0 = cnt_r; e0 = cnt_e;
        send_frame(8'h1B, 1'b0, 1'b1);
        n_cmp++;
        if (cnt_e - e0 !== 1 || cnt_p - p0 + cnt_r - r0 !== 0 || bus.key !== 8'h23) begin
            n_err++;
            $display("FAIL parity_err: got err=%0d strobes=%0d key=%h, want err=1 strobes=0 key=23",
                     cnt_e - e0, cnt_p - p0 + cnt_r - r0, bus.key);
        end
        send_byte(8'hF0);
        send_frame(8'h1B, 1'b0, 1'b1);
        send_byte(8'h1D);
        n_cmp++;
        if (cnt_p - p0 !== 1 || cnt_r - r0 !== 0 || bus.key !== 8'h1D) begin
            n_err++;
            $display("FAIL prefix_clear: got prs=%0d rel=%0d key=%h, want prs=1 rel=0 key=1d",
                     cnt_p - p0, cnt_r - r0, bus.key);
        end
        send_frame(8'h1C, 1'b0, 1'b0);
        n_cmp++;
        if (cnt_e - e0 !== 3 || cnt_p - p0 !== 1 || bus.key !== 8'h1D) begin
            n_err++;
            $display("FAIL stop_err: got err=%0d prs=%0d key=%h, want err=3 prs=1 key=1d",
                     cnt_e - e0, cnt_p - p0, bus.key);
        end
        $display("frame errors: err_count=%0d", cnt_e - e0);
    endtask

    task automatic test_timeout;
        int p0, e0;
        p0 = cnt_p; e0 = cnt_e;
        send_byte(8'hF0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (400) @(negedge clk);
        send_byte(8'h23);
        n_cmp++;
        if (cnt_p - p0 !== 1 || bus.key !== 8'h23 || cnt_e - e0 !== 0) begin
            n_err++;
            $display("FAIL timeout: got prs=%0d key=%h err=%0d, want prs=1 key=23 err=0",
                     cnt_p - p0, bus.key, cnt_e - e0);
        end
        $display("timeout then 23: key=%h", bus.key);
    endtask

    task automatic test_back_to_back;
        int p0;
        p0 = cnt_p;
        send_byte(8'h1D);
        send_byte(8'h1D);
        n_cmp++;
        if (cnt_p - p0 !== 2 || bus.key !== 8'h1D) begin
            n_err++;
            $display("FAIL back_to_back: got prs=%0d key=%h, want prs=2 key=1d", cnt_p - p0, bus.key);
        end
        $display("typematic 1D x2: presses=%0d", cnt_p - p0);
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d;
        int p0, r0, e0;
        d = 8'h1C;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(d[i]);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.key, bus.key_pressed, bus.key_released, bus.key_extended, bus.frame_err} !== 12'h000) begin
            n_err++;
            $display("FAIL midframe_reset: got key=%h p=%b r=%b x=%b e=%b, want all 0",
                     bus.key, bus.key_pressed, bus.key_released, bus.key_extended, bus.frame_err);
        end
        rst = 1'b1;
        p0 = cnt_p; r0 = cnt_r; e0 = cnt_e;
        send_byte(8'h1C);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (cnt_p - p0 !== 1 || cnt_r - r0 !== 0 || cnt_e - e0 !== 0 || bus.key !== 8'h1C) begin
            n_err++;
            $display("FAIL after_reset: got prs=%0d rel=%0d err=%0d key=%h, want prs=1 rel=0 err=0 key=1c",
                     cnt_p - p0, cnt_r - r0, cnt_e - e0, bus.key);
        end
        $display("reset mid-frame then 1C: key=%h", bus.key);
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_parity_err();
        test_timeout();
        test_back_to_back();
        test_reset_midframe();
        n_cmp++;
        if (excl_viol !== 0) begin
            n_err++;
            $display("FAIL strobe_exclusive: got %0d overlapping-strobe cycles, want 0", excl_viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ps2_key_receiver.md
# ps2_key_receiver

- Decodes PS/2 keyboard frames (scan code set 2) into the `key` / `key_pressed` pair that drives snake direction control.
- Synchronises the asynchronous `ps2_clk` and `ps2_data` lines, deserialises 11-bit frames and checks parity.
- Interprets the `E0` (extended) and `F0` (break) prefixes.
- Emits single-cycle strobes for make and break events, holding the last decoded code on `key`.

## Interface
- `TIMEOUT_CYCLES`, default 50000: number of `clk` cycles without a `ps2_clk` falling edge before a partial frame is aborted (1 ms at 50 MHz).
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `ps2_clk`  input  1  raw PS/2 clock line, asynchronous to `clk`.
- `ps2_data`  input  1  raw PS/2 data line, asynchronous to `clk`.
- `key`  output  8  last decoded scan code (prefixes excluded), held until the next event.
- `key_pressed`  output  1  one-cycle strobe on a make code.
- `key_released`  output  1  one-cycle strobe on a break code (code preceded by `F0`).
- `key_extended`  output  1  set if the last event was `E0`-prefixed; updated together with `key`.
- `frame_err`  output  1  one-cycle strobe on a parity or stop-bit error.

## Operation

**Synchronisation**
- `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser.
- A registered copy of the synced clock gives the falling-edge detect `fall = prev & ~sync`.
- Bits are sampled only on `fall`.

**Frame format**
- Start bit 0, then 8 data bits LSB first, then odd parity, then stop bit 1.

**Frame FSM** (states IDLE, DATA, PARITY, STOP; 3-bit bit counter; 8-bit shift register)
- IDLE:
  - On `fall` with data = 0, go to DATA and clear the counter.
  - On `fall` with data = 1 (bad start), stay in IDLE. No error is flagged.
- DATA: on each `fall`, shift in at the MSB (right shift). After 8 bits, go to PARITY.
- PARITY: on `fall`, capture the parity bit and go to STOP.
- STOP: on `fall`, return to IDLE.
  - If stop = 1 and the data ones-count plus the parity bit is odd, the byte is valid.
  - Otherwise, pulse `frame_err` and clear both prefix flags.

**Prefix and event handling** (per valid byte)
- `E0`: set `ext_pend`. No strobe.
- `F0`: set `brk_pend`. No strobe.
- Any other byte:
  - Set `key` to the byte and `key_extended` to `ext_pend`.
  - Pulse `key_released` if `brk_pend` is set, else pulse `key_pressed`.
  - Clear both prefix flags.
- Typematic repeats of a make code produce one `key_pressed` per frame. No de-duplication.

**Timeout**
- A watchdog counter runs while the FSM is not in IDLE. It clears on every `fall`.
- Reaching `TIMEOUT_CYCLES` forces IDLE and clears the shift register, the counter and both prefix flags.
- No `frame_err` is raised on timeout.

**Reset** (`rst` = 0, asynchronous, any time including mid-frame)
- FSM goes to IDLE. Counters, shift register and prefix flags clear.
- `key` = 0x00. `key_pressed`, `key_released`, `key_extended` and `frame_err` = 0.
- Synchroniser flops reset to 1 (idle bus level), so reset release never fabricates a falling edge.

## Timing
- Sync latency: a `ps2_clk` falling edge at the pin produces `fall` on the 2nd rising `clk` edge after it.
- Outputs are registered and update on the 3rd rising `clk` edge after the pin edge.
- `key`, `key_extended` and the strobe change in the same cycle. `key` is valid whenever `key_pressed` or `key_released` is high.
- All strobes are exactly one `clk` cycle wide. `key_pressed` and `key_released` are never high in the same cycle.
- `frame_err` is mutually exclusive with both event strobes.
- PS/2 bit period is ≥ 60 µs, so `clk` must be ≥ 100× the PS/2 clock rate. No back-pressure: a consumer must sample on the strobe.
- A `fall` arriving in the same cycle the watchdog expires: the timeout wins. That edge is dropped and the FSM restarts from IDLE.

## Test plan
- **Make code:** frame with data 0x1D, parity 1, stop 1 → `key` = 0x1D, `key_pressed` high for exactly 1 cycle, 3 clk edges after the stop-bit fall; `key_extended` = 0.
- **Break sequence:** frames `F0` then `1C` → no strobe after `F0`; after `1C`, `key_released` pulses once, `key` = 0x1C, `key_pressed` stays 0.
- **Extended code:** frames `E0` then `75`, then `E0`, `F0`, `75` → first `75` gives `key_pressed` with `key_extended` = 1; final `75` gives `key_released` with `key_extended` = 1; a following plain `23` gives `key_extended` = 0.
- **Parity error and prefix clear:** frame 0x1B with parity 0 → `frame_err` pulses once, no key strobe, `key` unchanged. `F0` followed by a bad-parity frame, then `1D` → `key_pressed`, not `key_released`.
- **Timeout:** 4 bits of a frame, then a pause longer than `TIMEOUT_CYCLES` (use 200 in the bench), then a clean 0x23 frame → `key` = 0x23 with `key_pressed`, and no `frame_err`.
- **Reset mid-frame:** assert `rst` low after 5 data bits, release, then send 0x1C → all outputs 0 during reset; afterwards exactly one `key_pressed` with `key` = 0x1C.
